// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal 2-bit branch predictor with self-initialising table and saturating stats
// Table init sweeps every entry after reset; training and stats are live only in RUN.
module branch_predictor #(
    parameter int         IDX_BITS   = 6,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         STAT_BITS  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 predict_valid,
    input  logic [31:0]          predict_pc,
    output logic                 shouldTakeBranch,
    output logic                 ready,
    input  logic                 resolve_valid,
    input  logic [31:0]          resolve_pc,
    input  logic                 resolve_taken,
    input  logic                 resolve_predicted,
    output logic                 mispredict,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispredict_count
);

    localparam int                   DEPTH    = 1 << IDX_BITS;
    localparam logic [0:0]           ST_INIT  = 1'b0;
    localparam logic [0:0]           ST_RUN   = 1'b1;
    localparam logic [IDX_BITS-1:0]  LAST_IDX = {IDX_BITS{1'b1}};
    localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

    logic [1:0]           table_q [DEPTH];
    logic [0:0]           state_q, state_d;
    logic [IDX_BITS-1:0]  init_idx_q, init_idx_d;
    logic                 mispredict_q, mispredict_d;
    logic [STAT_BITS-1:0] branch_count_q, branch_count_d;
    logic [STAT_BITS-1:0] mispredict_count_q, mispredict_count_d;

    logic                 wr_en;
    logic [IDX_BITS-1:0]  wr_idx;
    logic [1:0]           wr_data;
    logic [IDX_BITS-1:0]  pred_idx;
    logic [IDX_BITS-1:0]  res_idx;
    logic [1:0]           res_entry;
    logic                 res_miss;

    // Upper PC bits intentionally do not participate in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{predict_pc[31:IDX_BITS], resolve_pc[31:IDX_BITS]};

    assign pred_idx  = predict_pc[IDX_BITS-1:0];
    assign res_idx   = resolve_pc[IDX_BITS-1:0];
    assign res_entry = table_q[res_idx];
    assign res_miss  = resolve_taken != resolve_predicted;

    always_comb begin
        state_d            = state_q;
        init_idx_d         = init_idx_q;
        mispredict_d       = 1'b0;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        wr_en              = 1'b0;
        wr_idx             = res_idx;
        wr_data            = res_entry;
        if (state_q == ST_INIT) begin
            wr_en      = 1'b1;
            wr_idx     = init_idx_q;
            wr_data    = INIT_STATE;
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end else if (resolve_valid) begin
            wr_en = 1'b1;
            if (resolve_taken) begin
                wr_data = (res_entry == 2'b11) ? 2'b11 : res_entry + 2'd1;
            end else begin
                wr_data = (res_entry == 2'b00) ? 2'b00 : res_entry - 2'd1;
            end
            mispredict_d = res_miss;
            if (branch_count_q != STAT_MAX) begin
                branch_count_d = branch_count_q + 1'b1;
            end
            if (res_miss && (mispredict_count_q != STAT_MAX)) begin
                mispredict_count_d = mispredict_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= ST_INIT;
            init_idx_q         <= '0;
            mispredict_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            init_idx_q         <= init_idx_d;
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Table contents are not reset; the INIT sweep rewrites them.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            table_q[wr_idx] <= wr_data;
        end
    end

    assign ready            = (state_q == ST_RUN);
    assign shouldTakeBranch = ready & predict_valid & table_q[pred_idx][1];
    assign mispredict       = mispredict_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clock;
    logic        reset;
    logic        predict_valid;
    logic [31:0] predict_pc;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic        resolve_predicted;

    logic        stb, rdy, mis;
    logic [15:0] bcnt, mcnt;
    logic        stb4, rdy4, mis4;
    logic [3:0]  bcnt4, mcnt4;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clock(clock), .reset(reset),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .shouldTakeBranch(stb), .ready(rdy),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_predicted(resolve_predicted),
        .mispredict(mis), .branch_count(bcnt), .mispredict_count(mcnt)
    );

    branch_predictor #(.STAT_BITS(4)) dut4 (
        .clock(clock), .reset(reset),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .shouldTakeBranch(stb4), .ready(rdy4),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_predicted(resolve_predicted),
        .mispredict(mis4), .branch_count(bcnt4), .mispredict_count(mcnt4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reset for two cycles, then count cycles until ready; -1 means timeout.
    task automatic do_init(output int cycles, output bit stb_seen);
        cycles   = -1;
        stb_seen = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset         = 1'b0;
        predict_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            predict_pc = 32'(i);
            #1;
            if (rdy) begin
                cycles = i + 1;
                break;
            end
            if (stb) stb_seen = 1'b1;
        end
        predict_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic pred);
        @(negedge clock);
        resolve_valid     = 1'b1;
        resolve_pc        = pc;
        resolve_taken     = taken;
        resolve_predicted = pred;
        @(negedge clock);
        resolve_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        bit seen;
        do_init(cyc, seen);
        checks++;
        if (cyc !== 64) begin
            errors++;
            $display("FAIL init_latency: got %0d cycles, expected 64", cyc);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stb_during_init: got 1, expected 0");
        end
        checks++;
        if (bcnt !== 16'd0 || mcnt !== 16'd0 || mis !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: bc=%0d mc=%0d mis=%0b, expected 0 0 0", bcnt, mcnt, mis);
        end
    endtask

    task automatic test_training();
        logic taken_seq [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        logic exp_pred  [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 11; i++) begin
            train(32'h25, taken_seq[i], 1'b0);
            predict_valid = 1'b1;
            predict_pc    = 32'h25;
            #1;
            checks++;
            if (stb !== exp_pred[i]) begin
                errors++;
                $display("FAIL train_step%0d: stb=%0b, expected %0b", i, stb, exp_pred[i]);
            end
            predict_valid = 1'b0;
        end
    endtask

    task automatic test_alias();
        @(negedge clock);
        predict_valid = 1'b1;
        predict_pc    = 32'h45;
        #1;
        checks++;
        if (stb !== 1'b0) begin
            errors++;
            $display("FAIL alias_before: stb=%0b, expected 0", stb);
        end
        predict_valid = 1'b0;
        train(32'h05, 1'b1, 1'b0);
        train(32'h05, 1'b1, 1'b0);
        predict_valid = 1'b1;
        predict_pc    = 32'h45;
        #1;
        checks++;
        if (stb !== 1'b1) begin
            errors++;
            $display("FAIL alias_after: stb=%0b, expected 1", stb);
        end
        predict_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        @(negedge clock);
        predict_valid     = 1'b1;
        predict_pc        = 32'h10;
        resolve_valid     = 1'b1;
        resolve_pc        = 32'h10;
        resolve_taken     = 1'b1;
        resolve_predicted = 1'b0;
        #1;
        checks++;
        if (stb !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pre: stb=%0b, expected 0", stb);
        end
        @(negedge clock);
        resolve_valid = 1'b0;
        #1;
        checks++;
        if (stb !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_post: stb=%0b, expected 1", stb);
        end
        predict_valid = 1'b0;
    endtask

    task automatic test_mispredict();
        int cyc;
        bit seen;
        do_init(cyc, seen);
        checks++;
        if (cyc !== 64) begin
            errors++;
            $display("FAIL reinit_latency: got %0d, expected 64", cyc);
        end
        @(negedge clock);
        resolve_valid     = 1'b1;
        resolve_pc        = 32'h20;
        resolve_taken     = 1'b1;
        resolve_predicted = 1'b0;
        #1;
        checks++;
        if (mis !== 1'b0) begin
            errors++;
            $display("FAIL mis_cycle_n: mis=%0b, expected 0", mis);
        end
        @(negedge clock);
        resolve_pc        = 32'h21;
        resolve_taken     = 1'b0;
        resolve_predicted = 1'b0;
        #1;
        checks++;
        if (mis !== 1'b1 || bcnt !== 16'd1 || mcnt !== 16'd1) begin
            errors++;
            $display("FAIL mis_cycle_n1: mis=%0b bc=%0d mc=%0d, expected 1 1 1", mis, bcnt, mcnt);
        end
        @(negedge clock);
        resolve_valid = 1'b0;
        #1;
        checks++;
        if (mis !== 1'b0 || bcnt !== 16'd2 || mcnt !== 16'd1) begin
            errors++;
            $display("FAIL mis_match: mis=%0b bc=%0d mc=%0d, expected 0 2 1", mis, bcnt, mcnt);
        end
    endtask

    task automatic test_back_to_back();
        bit gap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            resolve_valid     = 1'b1;
            resolve_pc        = 32'h30;
            resolve_taken     = 1'b1;
            resolve_predicted = 1'b0;
            #1;
            if (i > 0 && mis !== 1'b1) gap = 1'b1;
        end
        @(negedge clock);
        resolve_valid = 1'b0;
        #1;
        checks++;
        if (gap !== 1'b0 || mis !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pulse: gap=%0b mis=%0b, expected 0 1", gap, mis);
        end
        checks++;
        if (bcnt4 !== 4'd15 || mcnt4 !== 4'd15) begin
            errors++;
            $display("FAIL sat4: bc=%0d mc=%0d, expected 15 15", bcnt4, mcnt4);
        end
        checks++;
        if (bcnt !== 16'd22 || mcnt !== 16'd21) begin
            errors++;
            $display("FAIL count16: bc=%0d mc=%0d, expected 22 21", bcnt, mcnt);
        end
        @(negedge clock);
        #1;
        checks++;
        if (mis !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: mis=%0b, expected 0", mis);
        end
    endtask

    task automatic test_mid_init_reset();
        bit bad = 1'b0;
        int cyc = -1;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset             = 1'b0;
        resolve_valid     = 1'b1;
        resolve_pc        = 32'h25;
        resolve_taken     = 1'b1;
        resolve_predicted = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #1;
            if (rdy !== 1'b0 || mis !== 1'b0 || bcnt !== 16'd0 || mcnt !== 16'd0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL init_ignores_training: rdy/mis/counters changed during INIT");
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (rdy) begin
                cyc = i + 1;
                break;
            end
        end
        resolve_valid = 1'b0;
        checks++;
        if (cyc !== 64) begin
            errors++;
            $display("FAIL mid_init_latency: got %0d, expected 64", cyc);
        end
        predict_valid = 1'b1;
        predict_pc    = 32'h25;
        #1;
        checks++;
        if (stb !== 1'b0 || bcnt !== 16'd0 || mcnt !== 16'd0) begin
            errors++;
            $display("FAIL post_init_state: stb=%0b bc=%0d mc=%0d, expected 0 0 0", stb, bcnt, mcnt);
        end
        predict_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        predict_valid     = 1'b0;
        predict_pc        = '0;
        resolve_valid     = 1'b0;
        resolve_pc        = '0;
        resolve_taken     = 1'b0;
        resolve_predicted = 1'b0;
        test_reset();
        test_training();
        test_alias();
        test_same_cycle();
        test_mispredict();
        test_back_to_back();
        test_mid_init_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch predictor for the fetch/decode stage. It answers the decoder's per-cycle taken/not-taken query.
- It is trained by the execute stage when a conditional branch (bne, blt, bex) resolves. It returns a registered mispredict flag used for pipeline flush.
- Keeps saturating performance counters for branches and mispredictions.
- Self-initialises its pattern table after reset through a small state machine.

Parameters:
- IDX_BITS, 6, table index width; table depth = 2^IDX_BITS entries of 2-bit counters.
- INIT_STATE, 2'b01, value written to every counter during initialisation (weakly not-taken).
- STAT_BITS, 16, width of the performance counters.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- predict_valid  input  1  decoder is presenting a conditional branch this cycle.
- predict_pc  input  32  PC of the branch being predicted.
- shouldTakeBranch  output  1  prediction, combinational from table state.
- ready  output  1  table initialised; predictions and training are live.
- resolve_valid  input  1  execute stage resolved a conditional branch this cycle.
- resolve_pc  input  32  PC of the resolved branch.
- resolve_taken  input  1  actual outcome.
- resolve_predicted  input  1  prediction that was used for this branch when it was fetched.
- mispredict  output  1  registered; outcome differed from prediction.
- branch_count  output  STAT_BITS  resolved branches since reset, saturating.
- mispredict_count  output  STAT_BITS  mispredictions since reset, saturating.

Behaviour:
- Index: the PC is word-addressed (increments by 1), so idx = pc[IDX_BITS-1:0]. Upper bits are ignored; aliasing is permitted.
- Prediction: shouldTakeBranch = ready & predict_valid & table[idx(predict_pc)][1]. It is 0 whenever ready=0.
- FSM states INIT and RUN.
  - Reset forces INIT with init_idx=0. Reset also clears ready, mispredict, branch_count and mispredict_count.
  - In INIT, each non-reset cycle writes INIT_STATE to table[init_idx] and then increments init_idx.
  - The cycle that writes entry 2^IDX_BITS-1 transitions to RUN. ready=1 from the next cycle, i.e. exactly 2^IDX_BITS cycles after reset deasserts.
  - Reset asserted mid-INIT restarts at init_idx=0. Reset asserted in RUN returns to INIT; table contents are not trusted until re-init completes.
- Training (RUN only, resolve_valid=1):
  - resolve_taken=1: table[idx(resolve_pc)] increments, saturating at 2'b11.
  - resolve_taken=0: the entry decrements, saturating at 2'b00.
  - Write occurs at the clock edge; a same-cycle prediction to the same index sees the pre-update value.
- Training is ignored entirely in INIT: no table write, no stat change, mispredict stays 0.
- mispredict: next-cycle registered value of (RUN & resolve_valid & (resolve_taken != resolve_predicted)). It is a one-cycle pulse per resolution and can be high on back-to-back cycles.
- branch_count increments on each RUN resolve_valid. mispredict_count increments on each mispredicting resolve. Both hold at all-ones (2^STAT_BITS-1) instead of wrapping.
- Single-ported table write: INIT writes and training writes are mutually exclusive by FSM state.

Test Plan:
- Reset for 2 cycles, then idle:
  - ready=0 for exactly 64 cycles, then 1.
  - shouldTakeBranch=0 throughout INIT even with predict_valid=1.
  - Counters read 0.
- After ready, resolve pc=0x25 taken twice:
  - Entry goes 01→10→11.
  - predict_pc=0x25 gives shouldTakeBranch=1.
  - Two more taken resolves keep it at 11.
  - Four not-taken resolves reach 00, then 00 holds.
- Aliasing: train pc=0x05 taken ×2, then predict pc=0x45 → shouldTakeBranch=1 (same index 5).
- Same-cycle predict and resolve at pc=0x10 with entry=01, resolve taken → shouldTakeBranch=0 that cycle, 1 the following cycle.
- Resolve with resolve_taken=1, resolve_predicted=0 on cycle N:
  - mispredict=1 on cycle N+1 only.
  - mispredict_count=1, branch_count=1.
  - A matching resolve on the next cycle gives mispredict=0.
- Set STAT_BITS=4 and issue 20 mispredicting resolves → both counters saturate at 15. Assert reset mid-INIT at cycle 30 → ready rises 64 cycles after that reset deasserts.
